// File: rtl/unpack_sync.sv
// Receive-side deserializer: hunts for the 32-bit preamble in a serial stream,
// then regroups the payload into words delivered over a valid/ready handshake.
module unpack_sync #(
  parameter int unsigned               SIZE_BIT_PACK    = 1976,
  parameter int unsigned               SIZE_OUTPUT_BIT  = 8,
  parameter int unsigned               SIZE_PREAMBLE    = 32,
  parameter logic [SIZE_PREAMBLE-1:0]  PREAMBLE         = 32'h1ACFFC1D,
  parameter int unsigned               PREAMBLE_ERR_MAX = 0,
  parameter int unsigned               LENGTH_PAYLOAD   = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_last,
  output logic                       o_sync,
  output logic [15:0]                o_pack_cnt
);

  localparam int unsigned FCW = $clog2(SIZE_PREAMBLE + 1);
  localparam int unsigned BCW = $clog2(SIZE_OUTPUT_BIT);
  localparam int unsigned WCW = $clog2(LENGTH_PAYLOAD);

  localparam logic [FCW-1:0] FILL_FULL = FCW'(SIZE_PREAMBLE);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(SIZE_OUTPUT_BIT - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(LENGTH_PAYLOAD - 1);

  typedef enum logic {ST_SEARCH, ST_PAYLOAD} state_t;

  state_t                     state_q,    state_d;
  logic [SIZE_PREAMBLE-1:0]   shift_q,    shift_d;
  logic [FCW-1:0]             fill_q,     fill_d;
  logic [BCW-1:0]             bit_cnt_q,  bit_cnt_d;
  logic [WCW-1:0]             word_cnt_q, word_cnt_d;
  logic [SIZE_OUTPUT_BIT-1:0] word_q,     word_d;
  logic [SIZE_OUTPUT_BIT-1:0] data_q,     data_d;
  logic                       valid_q,    valid_d;
  logic                       last_q,     last_d;
  logic                       sync_q,     sync_d;
  logic [15:0]                pack_cnt_q, pack_cnt_d;
  logic                       accept;

  function automatic int unsigned popcount(input logic [SIZE_PREAMBLE-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < SIZE_PREAMBLE; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Stall input only when a completed word would have nowhere to go.
  assign o_ready = !(state_q == ST_PAYLOAD && bit_cnt_q == BIT_LAST && valid_q && !i_ready);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    sync_d     = sync_q;
    pack_cnt_d = pack_cnt_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (accept) begin
      if (state_q == ST_SEARCH) begin
        shift_d = {shift_q[SIZE_PREAMBLE-2:0], i_data};
        fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FCW'(1);
        if (fill_d == FILL_FULL && popcount(shift_d ^ PREAMBLE) <= PREAMBLE_ERR_MAX) begin
          state_d    = ST_PAYLOAD;
          sync_d     = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end else begin
        word_d = {word_q[SIZE_OUTPUT_BIT-2:0], i_data};
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          data_d    = word_d;
          valid_d   = 1'b1;
          last_d    = (word_cnt_q == WORD_LAST);
          if (word_cnt_q == WORD_LAST) begin
            // Flush the hunter so payload bits never seed the next match.
            state_d    = ST_SEARCH;
            sync_d     = 1'b0;
            shift_d    = '0;
            fill_d     = '0;
            word_cnt_d = '0;
            pack_cnt_d = pack_cnt_q + 16'd1;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_SEARCH;
      shift_q    <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      sync_q     <= 1'b0;
      pack_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      sync_q     <= sync_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_sync     = sync_q;
  assign o_pack_cnt = pack_cnt_q;

endmodule

// File: tb/tb_unpack_sync.sv
// Directed bench for unpack_sync: lock, payload regrouping, backpressure,
// false lock, error-tolerant lock and back-to-back packets.
module tb_unpack_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_data, i_valid, i_ready;
  logic        o_ready, o_valid, o_last, o_sync;
  logic [7:0]  o_data;
  logic [15:0] o_pack_cnt;
  logic        o_ready_e, o_valid_e, o_last_e, o_sync_e;
  logic [7:0]  o_data_e;
  logic [15:0] o_pack_cnt_e;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] q[$];
  logic       m_valid    = 1'b0;
  logic       in_payload = 1'b0;
  int         pbit       = 0;
  int         stalls     = 0;

  always #5 clk = ~clk;

  unpack_sync dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_sync(o_sync), .o_pack_cnt(o_pack_cnt)
  );

  unpack_sync #(.PREAMBLE_ERR_MAX(2)) dut_e (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready_e), .o_data(o_data_e), .o_valid(o_valid_e), .i_ready(i_ready),
    .o_last(o_last_e), .o_sync(o_sync_e), .o_pack_cnt(o_pack_cnt_e)
  );

  // Record every word that completes a handshake on the coming edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && o_valid && i_ready) q.push_back({o_last, o_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic b, output logic acc);
    logic exp_rdy, hs, ld;
    @(negedge clk);
    i_valid = v;
    i_data  = b;
    #1;
    exp_rdy = !(in_payload && (pbit % 8 == 7) && m_valid && !i_ready);
    chk("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
    if (!exp_rdy) stalls++;
    acc = v && o_ready;
    hs  = m_valid && i_ready;
    ld  = acc && in_payload && (pbit % 8 == 7);
    m_valid = ld ? 1'b1 : (hs ? 1'b0 : m_valid);
    if (acc && in_payload) pbit++;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 1'b0, acc);
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 200) begin
      cycle(1'b1, b, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_pre();
    send_word(32'h1ACFFC1D, 32);
    chk("sync_before_lock", {31'd0, o_sync}, 32'd0);
    @(posedge clk);
    #1;
    chk("sync_after_lock", {31'd0, o_sync}, 32'd1);
    in_payload = 1'b1;
    pbit       = 0;
  endtask

  task automatic send_pkt(input int p);
    send_pre();
    for (int i = 0; i < 243; i++) send_word((p != 0) ? 32'(255 - i) : 32'(i), 8);
    in_payload = 1'b0;
  endtask

  task automatic check_stream(input int npk);
    int i, p;
    logic [7:0] exp;
    chk("word_count", q.size(), 32'(243 * npk));
    for (int k = 0; k < q.size() && k < 243 * npk; k++) begin
      p   = k / 243;
      i   = k % 243;
      exp = (p != 0) ? 8'(255 - i) : 8'(i);
      chk("word_data", {24'd0, q[k][7:0]}, {24'd0, exp});
      chk("word_last", {31'd0, q[k][8]}, {31'd0, (i == 242)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_sync", {31'd0, o_sync}, 32'd0);
    chk("rst_pack_cnt", {16'd0, o_pack_cnt}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    q.delete();
    m_valid    = 1'b0;
    in_payload = 1'b0;
    pbit       = 0;
  endtask

  initial begin
    logic        seen;
    logic [39:0] junk;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_data", {24'd0, o_data}, 32'd0);
    chk("init_last", {31'd0, o_last}, 32'd0);
    chk("init_valid", {31'd0, o_valid}, 32'd0);
    chk("init_sync", {31'd0, o_sync}, 32'd0);
    chk("init_pack_cnt", {16'd0, o_pack_cnt}, 32'd0);
    chk("init_ready", {31'd0, o_ready}, 32'd1);
    chk("init_e_data", {24'd0, o_data_e}, 32'd0);
    chk("init_e_last", {31'd0, o_last_e}, 32'd0);
    chk("init_e_pack_cnt", {16'd0, o_pack_cnt_e}, 32'd0);
    rst_n = 1'b1;

    // Clean packet
    send_pkt(0);
    idle(4);
    check_stream(1);
    chk("clean_sync_off", {31'd0, o_sync}, 32'd0);
    chk("clean_pack_cnt", {16'd0, o_pack_cnt}, 32'd1);

    // False lock, then a real lock abandoned by a mid-packet reset
    do_reset();
    send_word(32'h001ACFFC, 24);
    junk = 40'hAAAAAAAAAA;
    seen = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      send_bit(junk[i]);
      seen = seen | o_sync | o_valid;
    end
    idle(1);
    seen = seen | o_sync | o_valid;
    chk("false_lock", {31'd0, seen}, 32'd0);
    send_pre();
    send_word(32'hA5, 8);
    send_word(32'h3C, 8);
    send_word(32'h5, 4);
    idle(2);
    chk("after_lock_words", q.size(), 32'd2);
    if (q.size() >= 2) begin
      chk("after_lock_w0", {23'd0, q[0]}, 32'h0A5);
      chk("after_lock_w1", {23'd0, q[1]}, 32'h03C);
    end
    do_reset();
    idle(3);
    chk("midrst_no_word", q.size(), 32'd0);
    chk("midrst_sync", {31'd0, o_sync}, 32'd0);

    // Error-tolerant lock (two flipped bits locks, three does not)
    do_reset();
    send_word(32'h1ADFFC15, 32);
    chk("err2_before", {31'd0, o_sync_e}, 32'd0);
    @(posedge clk);
    #1;
    chk("err2_lock", {31'd0, o_sync_e}, 32'd1);
    chk("err2_strict_nolock", {31'd0, o_sync}, 32'd0);
    do_reset();
    send_word(32'h1ADFFC14, 32);
    idle(1);
    chk("err3_nolock", {31'd0, o_sync_e}, 32'd0);
    chk("err3_valid", {31'd0, o_valid_e}, 32'd0);

    // Backpressure
    do_reset();
    stalls = 0;
    fork
      send_pkt(0);
      begin
        for (int t = 0; t < 4000 && pbit < 80; t++) @(negedge clk);
        i_ready = 1'b0;
        repeat (30) @(negedge clk);
        i_ready = 1'b1;
      end
    join
    idle(4);
    check_stream(1);
    chk("bp_stalled", {31'd0, (stalls > 0)}, 32'd1);
    chk("bp_pack_cnt", {16'd0, o_pack_cnt}, 32'd1);

    // Back-to-back packets
    do_reset();
    send_pkt(0);
    send_pkt(1);
    idle(4);
    check_stream(2);
    chk("b2b_pack_cnt", {16'd0, o_pack_cnt}, 32'd2);
    chk("b2b_sync_off", {31'd0, o_sync}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unpack_sync.md
Name: unpack_sync

Overview:
- Receive-side counterpart of the packet serializer.
- Takes the 1-bit serial packet stream, searches for the 32-bit preamble and locks onto it.
- Regroups the following payload bits into bytes and delivers them downstream over a valid/ready handshake.
- After one full packet it drops lock and searches again.

Parameters:
SIZE_BIT_PACK, 1976, total packet length in bits, preamble included
SIZE_OUTPUT_BIT, 8, width of each reassembled payload word
SIZE_PREAMBLE, 32, preamble length in bits
PREAMBLE, 32'h1ACFFC1D, preamble pattern, transmitted MSB first
PREAMBLE_ERR_MAX, 0, maximum Hamming distance accepted as a preamble match
LENGTH_PAYLOAD, (SIZE_BIT_PACK-SIZE_PREAMBLE)/SIZE_OUTPUT_BIT, payload words per packet (243)

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_data  input  1  serial bit in
i_valid  input  1  i_data valid
o_ready  output  1  block accepts i_data this cycle
o_data  output  SIZE_OUTPUT_BIT  reassembled payload word
o_valid  output  1  o_data valid
i_ready  input  1  downstream accepts o_data
o_last  output  1  qualifies the final payload word of a packet (valid only with o_valid)
o_sync  output  1  high while locked (payload collection in progress)
o_pack_cnt  output  16  count of completed packets, wraps at 65535->0

Behaviour:
- Bit accept: a bit is accepted on a rising i_clk edge when i_valid && o_ready.
- Reset (i_reset_n low, asynchronous):
  - State SEARCH; shift register, fill counter, bit counter and word counter all cleared.
  - o_data=0, o_valid=0, o_last=0, o_sync=0, o_pack_cnt=0.
- SEARCH:
  - o_ready=1.
  - Each accepted bit shifts into the LSB of the 32-bit shift register.
  - fill_cnt increments, saturating at SIZE_PREAMBLE.
  - Match condition: fill_cnt (including the current bit) reaches SIZE_PREAMBLE AND popcount(next_shift ^ PREAMBLE) <= PREAMBLE_ERR_MAX.
  - On a match the state becomes PAYLOAD on that same edge; o_sync=1 from the next cycle. bit_cnt=0, word_cnt=0.
- PAYLOAD:
  - Bits assemble MSB first into the word register; bit_cnt runs 0..SIZE_OUTPUT_BIT-1.
  - Word completion: on the accept edge with bit_cnt==SIZE_OUTPUT_BIT-1, the assembled word loads into o_data and o_valid=1 from the next cycle (1-cycle latency).
  - o_last=1 with that word iff word_cnt==LENGTH_PAYLOAD-1.
  - Word handshake: o_valid stays high with o_data stable until a cycle with o_valid && i_ready. o_valid then drops, unless a new word loads on the same edge, in which case it stays high with the new data.
  - Backpressure: o_ready=0 iff state==PAYLOAD && bit_cnt==SIZE_OUTPUT_BIT-1 && o_valid && !i_ready. Otherwise o_ready=1. No word is ever lost or duplicated.
- Packet end: on the edge that loads the last word:
  - state returns to SEARCH; o_sync=0 from the next cycle.
  - Shift register and fill_cnt cleared, so payload bits never contribute to the next preamble match.
  - o_pack_cnt increments.
  - The last word still completes its handshake normally while the block is already in SEARCH.
- Simultaneous events: a downstream handshake and a new word load on the same edge give o_valid=1 with the new word.
- i_valid low: all counters and state hold.
- Reset mid-packet: abandons the packet; the partial word is discarded and o_pack_cnt is unaffected except by reset itself.
- Widths: word_cnt is $clog2(LENGTH_PAYLOAD) bits; the popcount is computed combinationally over 32 bits.

Test Plan:
- Reset: assert i_reset_n=0 mid-stream -> o_valid=0, o_sync=0, o_pack_cnt=0, o_ready=1 immediately, without waiting for a clock edge.
- Clean packet: 32 bits of 0x1ACFFC1D, then payload bytes 0x00..0xF2 MSB first, i_valid=1 continuously, i_ready=1:
  - o_sync=1 from the cycle after the 32nd bit.
  - 243 words out, 0x00..0xF2 in order.
  - o_last=1 only with 0xF2; o_sync=0 afterward; o_pack_cnt=1.
- False lock: 0x1ACFFC, then 40 random bits without the pattern, then 0x1ACFFC1D -> o_sync stays 0 until the complete pattern; no o_valid before lock.
- Error tolerance, with PREAMBLE_ERR_MAX=2:
  - preamble with bits 3 and 20 flipped -> locks;
  - preamble with 3 bits flipped -> no lock.
- Backpressure: during payload hold i_ready=0 for 30 cycles -> o_ready=0 while bit_cnt==7; o_data held; after release the output sequence is still exactly 0x00..0xF2.
- Back-to-back packets: two packets with no gap, the second payload 0xFF..0x0D -> both decoded; o_pack_cnt=2; no spurious lock from payload bits.
